// File: rtl/pipe_adder_pkg.sv
// ============================================================================
// pipe_adder_pkg : shared helpers and stage control type for pipe_adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipe_adder_pkg;

  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int slice_width(input int n, input int stages);
    return n / stages;
  endfunction

  function automatic logic signed_ovf(input logic a_sign, input logic b_sign,
                                      input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_slice.sv
// ============================================================================
// adder_slice : combinational W-bit add with carry in/out
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

`default_nettype wire

// File: rtl/pipe_adder.sv
// ============================================================================
// pipe_adder : N-bit add/subtract split into STAGES carry-chained slices,
//              one register stage per slice, valid/ready on both sides
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipe_adder #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  input  logic         sub,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] S,
  output logic         c_out,
  output logic         ovf
);
  import pipe_adder_pkg::*;

  localparam int W = slice_width(N, STAGES);

  // Package types cannot depend on N, so the width-dependent payload lives here.
  typedef struct packed {
    stage_ctl_t   ctl;
    logic [N-1:0] sum;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } stage_t;

  stage_t r_q   [STAGES];
  stage_t w_nxt [STAGES];
  stage_t w_last;
  logic   w_en;
  logic   w_unused_bits;

  assign w_last  = r_q[STAGES-1];
  assign w_en    = !w_last.ctl.valid || m_ready;
  assign s_ready = w_en;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      stage_t       w_prev;
      stage_t       w_cur;
      logic [W-1:0] w_sum;
      logic         w_co;

      if (k == 0) begin : g_head
        // Subtraction becomes A + ~B + ~c_in; stage 0 carry slot holds cx.
        always_comb begin
          w_prev           = '0;
          w_prev.ctl.valid = s_valid;
          w_prev.ctl.carry = sub ? ~c_in : c_in;
          w_prev.a         = A;
          w_prev.b         = sub ? ~B : B;
        end
      end else begin : g_body
        assign w_prev = r_q[k-1];
      end

      adder_slice #(.W(W)) u_slice (
        .a  (w_prev.a[k*W +: W]),
        .b  (w_prev.b[k*W +: W]),
        .ci (w_prev.ctl.carry),
        .s  (w_sum),
        .co (w_co)
      );

      always_comb begin
        w_cur                 = w_prev;
        w_cur.sum[k*W +: W]   = w_sum;
        w_cur.ctl.carry       = w_co;
      end

      assign w_nxt[k] = w_cur;
    end
  endgenerate

  // Single global enable: the whole pipe advances or holds together.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < STAGES; k++) begin
        r_q[k] <= '0;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_q[k] <= w_nxt[k];
      end
    end
  end

  assign m_valid = w_last.ctl.valid;
  assign S       = w_last.sum;
  assign c_out   = w_last.ctl.carry;
  assign ovf     = signed_ovf(w_last.a[N-1], w_last.b[N-1], w_last.sum[N-1]);

  // Only the sign bits of the operands are needed past the last slice.
  assign w_unused_bits = ^{w_last.a[N-2:0], w_last.b[N-2:0]};

endmodule

`default_nettype wire

// File: tb/tb_pipe_adder.sv
// ============================================================================
// tb_pipe_adder : scoreboard testbench for pipe_adder (N=8, STAGES=2)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipe_adder;

  localparam int N      = 8;
  localparam int STAGES = 2;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [N-1:0] S;
  logic         c_out;
  logic         ovf;

  pipe_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .A       (A),
    .B       (B),
    .c_in    (c_in),
    .sub     (sub),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .S       (S),
    .c_out   (c_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic ci, input logic su);
    exp_t         e;
    logic [N-1:0] bx;
    logic         cx;
    logic [N:0]   r;
    bx    = su ? ~b : b;
    cx    = su ? ~ci : ci;
    r     = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, cx};
    e.s   = r[N-1:0];
    e.c   = r[N];
    e.o   = (a[N-1] == bx[N-1]) && (r[N-1] != a[N-1]);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Scoreboard: push on acceptance, pop and compare on output transfer.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (rstn) begin
      if (s_valid && s_ready) begin
        e     = cur;
        e.acc = cyc;
        sb.push_back(e);
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", {31'd0, m_valid}, 32'd0);
        end else begin
          g = sb.pop_front();
          check_eq("S", {24'd0, S}, {24'd0, g.s});
          check_eq("c_out", {31'd0, c_out}, {31'd0, g.c});
          check_eq("ovf", {31'd0, ovf}, {31'd0, g.o});
          if (g.lat) check_eq("latency", cyc - g.acc, STAGES);
        end
      end
    end
  end

  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                          input logic su, input logic [N-1:0] es, input logic ec,
                          input logic eo, input bit lat);
    A       = a;
    B       = b;
    c_in    = ci;
    sub     = su;
    cur.s   = es;
    cur.c   = ec;
    cur.o   = eo;
    cur.acc = 0;
    cur.lat = lat;
    s_valid = 1'b1;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                       input logic su, input logic [N-1:0] es, input logic ec,
                       input logic eo, input bit lat);
    start_op(a, b, ci, su, es, ec, eo, lat);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   n;
    int   sent;
    bit   pend;

    // Reset state
    idle(2);
    check_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("rst_S", {24'd0, S}, 32'd0);
    check_eq("rst_c_out", {31'd0, c_out}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    rstn = 1'b1;
    #1;
    check_eq("rst_s_ready", {31'd0, s_ready}, 32'd1);
    idle(1);

    // Plain add with latency
    issue(8'd5, 8'd10, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Back-to-back
    issue(8'd30, 8'hF6, 1'b0, 1'b0, 8'd20, 1'b1, 1'b0, 1'b1);
    issue(8'd5, 8'd10, 1'b1, 1'b0, 8'd16, 1'b0, 1'b0, 1'b1);
    idle(4);

    // Signed overflow both directions
    issue(8'd127, 8'd1, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    issue(8'h80, 8'hFF, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b1);
    idle(4);

    // Subtraction
    issue(8'd5, 8'd10, 1'b0, 1'b1, 8'hFB, 1'b0, 1'b0, 1'b1);
    issue(8'd10, 8'd5, 1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 1'b1);
    idle(4);

    // Backpressure: stall output for 4 cycles with a third op waiting
    issue(8'd1, 8'd2, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    issue(8'd100, 8'd100, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!m_valid && n < 20) begin
      idle(1);
      n++;
    end
    check_eq("bp_m_valid_rise", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b0;
    start_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check_eq("bp_s_ready", {31'd0, s_ready}, 32'd0);
      check_eq("bp_m_valid", {31'd0, m_valid}, 32'd1);
      if (sb.size() != 0) check_eq("bp_S_hold", {24'd0, S}, {24'd0, sb[0].s});
      else check_eq("bp_sb_nonempty", 32'd0, 32'd1);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    wait_accept();
    idle(5);

    // Reset with two ops in flight
    issue(8'd7, 8'd8, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0, 1'b0);
    issue(8'd9, 8'd9, 1'b0, 1'b0, 8'd18, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    sb.delete();
    #1;
    check_eq("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    check_eq("midrst_S", {24'd0, S}, 32'd0);
    idle(2);
    rstn = 1'b1;
    idle(6);

    // Random ops with random backpressure
    sent = 0;
    pend = 1'b0;
    while (sent < 200) begin
      if (!pend && $urandom_range(3) != 0) begin
        e = model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        A = 8'($urandom);
        B = 8'($urandom);
        c_in = 1'($urandom);
        sub = 1'($urandom);
        e = model(A, B, c_in, sub);
        cur = e;
        pend = 1'b1;
      end
      s_valid = pend;
      m_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      if (s_valid && s_ready) begin
        pend = 1'b0;
        sent++;
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1);
      n++;
    end
    check_eq("drain_empty", sb.size(), 32'd0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
